seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Parametrised successor to the single-digit combinational 7-segment decoder. It captures a binary value on a load strobe and converts it to BCD sequentially (double-dabble, one bit per cycle). It then time-multiplexes NUM_DIGITS digits onto one shared segment bus with a one-hot digit enable, and adds leading-zero blanking, overflow indication and output polarity selection. It sits between the reaction-time counter and the board-level display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- VALUE_W, 14: width of the binary input value, 1..27.
- SCAN_DIV, 1000: clk cycles each digit stays enabled, >=1.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0 (common anode).
- AN_ACTIVE_LOW, 1: 1 = digit enabled when its bit is 0.
- BLANK_LEADING, 1: 1 = suppress leading zeros; digit 0 is never blanked.

Ports:
- clk, in, 1: single system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- value, in, VALUE_W: binary value to display; sampled only when load=1.
- load, in, 1: capture strobe, one cycle.
- busy, out, 1: conversion in progress.
- overflow, out, 1: displayed value is >= 10^NUM_DIGITS.
- seg, out, 7: segment bus, bit order {g,f,e,d,c,b,a}.
- an, out, NUM_DIGITS: digit enable, one-hot (polarity set by AN_ACTIVE_LOW).
- digit_idx, out, clog2(NUM_DIGITS) (min 1): index of the currently enabled digit.

Behaviour:
- Reset (async assert, sync deassert on the internal path). All of the following take their reset value:
  - seg = all segments off (polarity applied); an = all digits off.
  - busy=0, overflow=0, digit_idx=0, prescaler=0.
  - Display BCD register = 0; pending flag = 0; conversion FSM = IDLE.
- Conversion FSM, states IDLE -> SHIFT -> COMMIT -> IDLE:
  - IDLE: on load=1, capture value into the shift register, set the overflow candidate (value >= 10^NUM_DIGITS), busy=1, go to SHIFT.
  - SHIFT: exactly VALUE_W cycles of double-dabble. Each cycle, add 3 to every BCD nibble >=5, then shift left by 1. BCD working register is 4*NUM_DIGITS bits; bits shifted out the top are discarded (overflow is already flagged).
  - COMMIT: one cycle. Copy the BCD working register and the overflow candidate into the display registers, then busy=0 and go to IDLE.
  - Latency: load in cycle 0 -> display registers updated at the end of cycle VALUE_W+1. busy is high in cycles 1..VALUE_W+1.
  - Display registers change only in COMMIT, so the displayed number never tears.
- load while busy:
  - The value is captured into a single pending slot; a later load overwrites it (latest wins).
  - After COMMIT, if pending=1, the FSM goes directly to SHIFT with the pending value and busy stays high.
  - load in the same cycle as COMMIT is treated as pending.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit_idx advances: digit_idx = NUM_DIGITS-1 wraps to 0.
  - Scanning runs continuously and is independent of busy.
- Digit content for the digit at digit_idx = i:
  - overflow=1: every digit shows dash (only segment g lit).
  - Else if BLANK_LEADING=1, i>0 and display nibbles i..NUM_DIGITS-1 are all zero: blank.
  - Else: decimal glyph of nibble i. Glyph 7 lights a,b,c only. Nibble values >9 cannot occur; if they do, show blank.
- seg and an are registered: one clk of latency after digit_idx or the display registers change. an has exactly one active bit at all times after the first post-reset clock.

Decomposition:
- seg7_pkg holds:
  - Glyph constants GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK, in active-high {g..a} form.
  - A function digit_to_glyph(nibble).
  - A function pow10(n) used for the overflow threshold.
  - The FSM state enum for IDLE, SHIFT, COMMIT.
  - Polarity is applied only at the output register.
- Sub-module seg7_bin2bcd implements the sequential double-dabble with its start/busy/done handshake and the pending slot. The top level keeps the prescaler, scan index, blanking and output registers.

Test Plan:
- Reset mid-conversion: load=1234, then rst asserted at cycle 5 -> seg all off and an all off immediately (asynchronous); busy=0. After release, the display shows "   0": digit 0 glyph 0 (seg=7'b1000000), digits 1..3 blank.
- Latency: NUM_DIGITS=4, VALUE_W=14, SCAN_DIV=4, load value=1234 -> busy high for exactly 15 cycles. A full scan then shows digit0=4 (0011001), digit1=3 (0110000), digit2=2 (0100100), digit3=1 (1111001); each digit's an bit is low for 4 cycles.
- Blanking: value=7 -> digits 1..3 seg=1111111, digit0=1111000. With BLANK_LEADING=0, value=7 -> digits 1..3 show 1000000.
- Overflow: VALUE_W=14, value=12000 -> overflow=1 and all digits seg=0111111 (dash). A following load of 9999 -> overflow=0 and all digits show 0010000.
- Back-to-back loads: load 100 at cycle 0, 200 at cycle 3, 300 at cycle 4 -> 100 commits at cycle 15, then 300 commits at cycle 30; 200 never appears; busy stays high continuously from cycle 1 through cycle 30.
- Scan wrap and polarity: SCAN_DIV=1, AN_ACTIVE_LOW=0, SEG_ACTIVE_LOW=0 -> digit_idx sequence 0,1,2,3,0 on consecutive clocks; an one-hot active-high; seg equals the bitwise inverse of the active-low glyphs.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types, glyph table and helper functions for the 7-segment scan driver.
package seg7_scan_driver_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b0111111;
  localparam logic [6:0] GLYPH_1     = 7'b0000110;
  localparam logic [6:0] GLYPH_2     = 7'b1011011;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_4     = 7'b1100110;
  localparam logic [6:0] GLYPH_5     = 7'b1101101;
  localparam logic [6:0] GLYPH_6     = 7'b1111101;
  localparam logic [6:0] GLYPH_7     = 7'b0000111;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  function automatic logic [6:0] digit_to_glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  // Width of a digit index; never below one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/load handshake and display bus of the scan driver.
interface seg7_scan_driver_if
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
);
  localparam int IDX_W = idx_w(NUM_DIGITS);

  logic [VALUE_W-1:0]    value;
  logic                  load;
  logic                  busy;
  logic                  overflow;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic [IDX_W-1:0]      digit_idx;

  modport master (output value, load, input busy, overflow, seg, an, digit_idx);
  modport slave  (input value, load, output busy, overflow, seg, an, digit_idx);
endinterface

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble converter with a single latest-wins pending slot.
module seg7_scan_driver_bin2bcd
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  output logic                    busy,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [31:0]      OVF_LIMIT = pow10(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(VALUE_W - 1);

  conv_state_e        state_q, state_d;
  logic [VALUE_W-1:0] bin_q, pend_val_q, start_val;
  logic [BCD_W-1:0]   work_q, adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_cand_q, pend_q, start, last_shift;

  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (b[4*k +: 4] >= 4'd5) r[4*k +: 4] = b[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic over_limit(input logic [VALUE_W-1:0] v);
    return 32'(v) >= OVF_LIMIT;
  endfunction

  // A conversion starts from IDLE on load, or straight out of COMMIT when
  // a load arrives now or one is waiting in the pending slot (fresh load wins).
  always_comb begin
    start      = ((state_q == IDLE) && load) || ((state_q == COMMIT) && (load || pend_q));
    start_val  = load ? value : pend_val_q;
    last_shift = (state_q == SHIFT) && (cnt_q == LAST_BIT);
    adj        = dabble_adjust(work_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = COMMIT;
      COMMIT:  state_d = (load || pend_q) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Control: bit counter, overflow candidate, pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ovf_cand_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      if (start) begin
        cnt_q      <= '0;
        ovf_cand_q <= over_limit(start_val);
      end else if (state_q == SHIFT) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == COMMIT)              pend_q <= 1'b0;
      else if ((state_q == SHIFT) && load) pend_q <= 1'b1;
    end
  end

  // Datapath: shift/add-3 working registers and pending value
  always_ff @(posedge clk) begin
    if (start) begin
      bin_q  <= start_val;
      work_q <= '0;
    end else if (state_q == SHIFT) begin
      work_q <= {adj[BCD_W-2:0], bin_q[VALUE_W-1]};
      bin_q  <= bin_q << 1;
    end
    if ((state_q == SHIFT) && load) pend_val_q <= value;
  end

  // Display registers change only in COMMIT so the shown number never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd      <= '0;
      overflow <= 1'b0;
    end else if (state_q == COMMIT) begin
      bcd      <= work_q;
      overflow <= ovf_cand_q;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: BCD conversion, digit scan, blanking, polarity.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int VALUE_W        = 14,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int IDX_W = idx_w(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [4*NUM_DIGITS-1:0] bcd_disp;
  logic                    ovf_disp, busy_w;
  logic [PRE_W-1:0]        presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [3:0]              nib_p0;
  logic                    upper_zero_p0;
  logic [6:0]              glyph_p0, seg_p1;
  logic [NUM_DIGITS-1:0]   onehot_p0, an_p1;

  seg7_scan_driver_bin2bcd #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .value    (bus.value),
    .load     (bus.load),
    .busy     (busy_w),
    .overflow (ovf_disp),
    .bcd      (bcd_disp)
  );

  // Prescaler and digit index: free-running, independent of conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Stage p0: pick nibble, decide dash/blank/digit, all in active-high form
  always_comb begin
    nib_p0        = 4'd0;
    upper_zero_p0 = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(idx_q)) nib_p0 = bcd_disp[4*k +: 4];
      if ((k >= int'(idx_q)) && (bcd_disp[4*k +: 4] != 4'd0)) upper_zero_p0 = 1'b0;
    end
    if (ovf_disp)
      glyph_p0 = GLYPH_DASH;
    else if ((BLANK_LEADING != 0) && (idx_q != '0) && upper_zero_p0)
      glyph_p0 = GLYPH_BLANK;
    else
      glyph_p0 = digit_to_glyph(nib_p0);
    onehot_p0 = NUM_DIGITS'(1) << idx_q;
  end

  // Stage p1: output registers, polarity applied here only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_p1 <= SEG_OFF;
      an_p1  <= AN_OFF;
    end else begin
      seg_p1 <= (SEG_ACTIVE_LOW != 0) ? ~glyph_p0 : glyph_p0;
      an_p1  <= (AN_ACTIVE_LOW != 0) ? ~onehot_p0 : onehot_p0;
    end
  end

  assign bus.seg       = seg_p1;
  assign bus.an        = an_p1;
  assign bus.digit_idx = idx_q;
  assign bus.busy      = busy_w;
  assign bus.overflow  = ovf_disp;

endmodule
